axis_pkt_monitor: RTL
=====================

Name: axis_pkt_monitor

Overview:
- In-line AXI4-Stream checker between the packet FIFO output and pkt_writer, on the 512-bit tdata/tkeep/tlast bus.
- Forwards every beat unchanged through a registered skid slice.
- Checks framing legality and keeps packet, byte and error statistics, so the replay-to-writer path is self-checking in simulation and on hardware.

Parameters:
- TDATA_WIDTH, 512, stream data width in bits; must be a multiple of 8.
- TKEEP_WIDTH, TDATA_WIDTH/8, byte-enable width.
- MIN_PKT_BYTES, 60, shortest legal packet; a shorter packet is a runt.
- MAX_PKT_BYTES, 1518, longest legal packet; a longer packet is a giant.
- LEN_WIDTH, 16, width of the packet length accumulator.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  TDATA_WIDTH  input data.
- s_axis_tkeep  in  TKEEP_WIDTH  input byte enables; bit0 is byte 0.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  forwarded data.
- m_axis_tkeep  out  TKEEP_WIDTH  forwarded byte enables.
- m_axis_tlast  out  1  forwarded end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- stats_clr  in  1  one-cycle pulse that clears all statistics.
- pkt_cnt  out  32  completed packets; wraps.
- byte_cnt  out  64  accepted bytes (sum of tkeep popcounts over completed packets); wraps.
- err_pkt_cnt  out  32  packets with at least one error; wraps.
- err_flags  out  4  sticky flags: [0] KEEP, [1] PARTIAL, [2] RUNT, [3] GIANT.
- last_pkt_len  out  LEN_WIDTH  byte length of the most recent completed packet.
- pkt_done  out  1  one-cycle pulse; the statistics were updated this cycle.

Behaviour:
- Reset is synchronous: a clocked rst=1 clears everything.
- Reset values: m_axis_tvalid=0, s_axis_tready=0 while rst=1, and 1 in the first cycle after rst deasserts; all counters, err_flags, last_pkt_len and pkt_done are 0; FSM is in IDLE.
- Data path is a two-entry skid buffer (main register plus skid register):
  - s_axis_tready is registered and equals !skid_valid; it does not depend combinationally on m_axis_tready.
  - Latency is 1 cycle from input handshake to m_axis_tvalid.
  - Full throughput of 1 beat/clk when m_axis_tready is held high.
  - m_axis_* stays stable while tvalid=1 and tready=0.
  - Beat order and contents are preserved exactly, including tkeep=0 beats.
- Monitoring samples input handshakes only (s_axis_tvalid && s_axis_tready).
- Beat byte count = popcount(s_axis_tkeep), range 0..TKEEP_WIDTH.
- FSM:
  - IDLE: on a handshake with tlast=0, go to IN_PKT. On a handshake with tlast=1, complete a single-beat packet and stay in IDLE.
  - IN_PKT: accumulate every handshake. On tlast, complete the packet and return to IDLE.
- Length accumulator is LEN_WIDTH bits and saturates at all-ones. A saturated packet is also a giant.
- Per-packet error bits are OR-accumulated across beats and cleared at packet completion:
  - KEEP: tkeep is 0, or tkeep is not of the form 2^n-1 (non-contiguous, or not LSB-aligned).
  - PARTIAL: a beat with tlast=0 has tkeep not all-ones.
  - RUNT: final length < MIN_PKT_BYTES.
  - GIANT: final length > MAX_PKT_BYTES.
- Completion (the cycle after the tlast handshake):
  - pkt_done=1.
  - pkt_cnt+1 and byte_cnt+len.
  - last_pkt_len=len.
  - err_pkt_cnt+1 if any error bit is set.
  - err_flags |= packet error bits.
- stats_clr:
  - Coincident with a completion: counters load this packet's contribution (clear then add).
  - During a packet: clears the statistics only; the in-flight length accumulator and FSM state are kept.
  - pkt_done is unaffected by stats_clr.
- Counters wrap modulo 2^width; err_flags only clear on rst or stats_clr.
- Reset mid-packet: the partial packet is discarded, and any skid contents are dropped. The next beat starts a new packet.

Decomposition:
- Package axis_pkt_pkg holds:
  - err_idx_e enum (KEEP=0, PARTIAL=1, RUNT=2, GIANT=3).
  - The popcount and keep_is_contiguous functions.
  - A monitor_state_e enum (IDLE, IN_PKT).
- One sub-module, axis_skid_slice, implements the parameterised two-entry register slice carrying {tdata, tkeep, tlast}.

Test Plan:
- Single 64-byte packet (1 beat, tkeep all-ones, tlast) with m_axis_tready=1 -> output 1 cycle later; pkt_cnt=1, byte_cnt=64, last_pkt_len=64, err_flags=0.
- 3-beat packet with last tkeep=64'h3FF -> len=138; 10 back-to-back packets with continuous ready -> no bubbles, pkt_cnt=10, byte_cnt=1380.
- Random m_axis_tready (50%) over 1000 random packets -> output stream identical to input and no beat lost; byte_cnt equals the reference-model sum.
- Error cases, each checked via err_flags and err_pkt_cnt:
  - Last-beat tkeep=64'h0F0 -> err_flags[0].
  - Mid-beat tkeep=64'h7F with tlast=0 -> err_flags[1].
  - Single beat of 40 bytes -> err_flags[2].
  - 25 full beats (1600 bytes) -> err_flags[3].
- stats_clr in the same cycle as a 64-byte completion -> pkt_cnt=1, byte_cnt=64, not 0.
- rst asserted after beat 2 of a 5-beat packet, then a clean 1-beat 100-byte packet -> pkt_cnt=1, last_pkt_len=100, err_flags=0.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI4-Stream packet monitor.
// Keep-mask helpers take a zero-extended mask so one definition serves any keep width.
package axis_pkt_pkg;

   localparam int MAX_KEEP_WIDTH = 256;
   localparam int COUNT_WIDTH    = 16;

   typedef enum logic [1:0] {
      KEEP    = 2'd0,
      PARTIAL = 2'd1,
      RUNT    = 2'd2,
      GIANT   = 2'd3
   } err_idx_e;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } monitor_state_e;

   function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [MAX_KEEP_WIDTH-1:0] keep);
      logic [COUNT_WIDTH-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
         cnt = cnt + COUNT_WIDTH'(keep[i]);
      end
      return cnt;
   endfunction

   // Legal masks are 2^n-1 with n>0: adding one to such a mask shares no set bit with it.
   function automatic logic keep_is_contiguous(input logic [MAX_KEEP_WIDTH-1:0] keep);
      return (keep != '0) && ((keep & (keep + MAX_KEEP_WIDTH'(1))) == '0);
   endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry register slice (main + skid) with a registered upstream ready.
// Ready never depends combinationally on the downstream ready.
module axis_skid_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             main_valid;
   logic             skid_valid;
   logic             skid_valid_next;
   logic             ready_q;
   logic             s_hs;
   logic             main_free;

   assign s_hs      = s_valid && ready_q;
   assign main_free = !main_valid || m_ready;

   // The skid entry only fills when a beat arrives while the main entry is stalled.
   always_comb begin
      skid_valid_next = skid_valid;
      if (main_free) begin
         skid_valid_next = 1'b0;
      end else if (s_hs) begin
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         skid_valid <= skid_valid_next;
         ready_q    <= !skid_valid_next;
         if (main_free) begin
            if (skid_valid) begin
               main_data  <= skid_data;
               main_valid <= 1'b1;
            end else begin
               main_valid <= s_hs;
               if (s_hs) begin
                  main_data <= s_data;
               end
            end
         end else if (s_hs) begin
            skid_data <= s_data;
         end
      end
   end

   assign s_ready = ready_q;
   assign m_data  = main_data;
   assign m_valid = main_valid;

endmodule

// File: rtl/axis_pkt_monitor.sv
// In-line AXI4-Stream framing checker: forwards beats through a skid slice and
// keeps packet, byte and error statistics from the input handshakes.
module axis_pkt_monitor #(
   parameter int TDATA_WIDTH   = 512,
   parameter int TKEEP_WIDTH   = TDATA_WIDTH / 8,
   parameter int MIN_PKT_BYTES = 60,
   parameter int MAX_PKT_BYTES = 1518,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   input  logic                   stats_clr,
   output logic [31:0]            pkt_cnt,
   output logic [63:0]            byte_cnt,
   output logic [31:0]            err_pkt_cnt,
   output logic [3:0]             err_flags,
   output logic [LEN_WIDTH-1:0]   last_pkt_len,
   output logic                   pkt_done
);

   import axis_pkt_pkg::*;

   localparam int PAYLOAD_WIDTH = TDATA_WIDTH + TKEEP_WIDTH + 1;
   localparam logic [LEN_WIDTH-1:0] MIN_LEN = LEN_WIDTH'(MIN_PKT_BYTES);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_BYTES);

   logic [PAYLOAD_WIDTH-1:0] m_payload;

   axis_skid_slice #(
      .WIDTH(PAYLOAD_WIDTH)
   ) u_slice (
      .clk    (clk),
      .rst    (rst),
      .s_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
      .s_valid(s_axis_tvalid),
      .s_ready(s_axis_tready),
      .m_data (m_payload),
      .m_valid(m_axis_tvalid),
      .m_ready(m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = m_payload;

   monitor_state_e         state;
   logic [LEN_WIDTH-1:0]   len_acc;
   logic [3:0]             err_acc;
   logic                   hs;
   logic                   complete;
   logic [COUNT_WIDTH-1:0] beat_bytes;
   logic [LEN_WIDTH:0]     len_sum;
   logic [LEN_WIDTH-1:0]   len_next;
   logic [3:0]             beat_err;
   logic [3:0]             pkt_err;

   assign hs         = s_axis_tvalid && s_axis_tready;
   assign complete   = hs && s_axis_tlast;
   assign beat_bytes = popcount(MAX_KEEP_WIDTH'(s_axis_tkeep));
   assign len_sum    = {1'b0, len_acc} + (LEN_WIDTH + 1)'(beat_bytes);
   assign len_next   = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

   // A length stuck at all-ones has saturated and is reported as a giant.
   always_comb begin
      beat_err          = '0;
      beat_err[KEEP]    = !keep_is_contiguous(MAX_KEEP_WIDTH'(s_axis_tkeep));
      beat_err[PARTIAL] = !s_axis_tlast && !(&s_axis_tkeep);
      pkt_err           = err_acc | beat_err;
      pkt_err[RUNT]     = len_next < MIN_LEN;
      pkt_err[GIANT]    = (len_next > MAX_LEN) || (&len_next);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         len_acc <= '0;
         err_acc <= '0;
      end else if (hs) begin
         if (s_axis_tlast) begin
            state   <= IDLE;
            len_acc <= '0;
            err_acc <= '0;
         end else begin
            state   <= IN_PKT;
            len_acc <= len_next;
            err_acc <= err_acc | beat_err;
         end
      end
   end

   // A clear coincident with a completion leaves exactly that packet's contribution.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt      <= '0;
         byte_cnt     <= '0;
         err_pkt_cnt  <= '0;
         err_flags    <= '0;
         last_pkt_len <= '0;
         pkt_done     <= 1'b0;
      end else begin
         pkt_done    <= complete;
         pkt_cnt     <= (stats_clr ? 32'd0 : pkt_cnt) + {31'd0, complete};
         byte_cnt    <= (stats_clr ? 64'd0 : byte_cnt) + (complete ? 64'(len_next) : 64'd0);
         err_pkt_cnt <= (stats_clr ? 32'd0 : err_pkt_cnt) + {31'd0, complete && (|pkt_err)};
         err_flags   <= (stats_clr ? 4'd0 : err_flags) | (complete ? pkt_err : 4'd0);
         if (complete) begin
            last_pkt_len <= len_next;
         end else if (stats_clr) begin
            last_pkt_len <= '0;
         end
      end
   end

endmodule
